// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall unit
module fwd_hazard_unit #(
    parameter int REG_AW     = 3,
    parameter int R0_IS_ZERO = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    logic   ex_load_q;
    logic   id_advance;
    logic   load_hit;

    function automatic logic produces(input stage_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.wr && (s.rd == r) && !((R0_IS_ZERO != 0) && (r == '0));
    endfunction

    // Youngest in-flight producer wins; the EX-load case never reaches here because it stalls.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] r,
                                           input stage_t ex, input stage_t mem, input stage_t wb);
        if (!used)                 return 2'b00;
        else if (produces(ex, r))  return 2'b10;
        else if (produces(mem, r)) return 2'b01;
        else if (produces(wb, r))  return 2'b11;
        else                       return 2'b00;
    endfunction

    always_comb begin
        load_hit = ex_load_q && ((id_rs1_used && produces(ex_q, id_rs1)) ||
                                 (id_rs2_used && produces(ex_q, id_rs2)));
        stall      = !flush && id_valid && load_hit;
        id_advance = id_valid && !stall && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_load_q   <= 1'b0;
            fwd_a       <= 2'b00;
            fwd_b       <= 2'b00;
            stall_count <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (id_advance) begin
                ex_q      <= '{valid: 1'b1, rd: id_rd, wr: id_wr_en};
                ex_load_q <= id_is_load;
                fwd_a     <= fwd_sel(id_rs1_used, id_rs1, ex_q, mem_q, wb_q);
                fwd_b     <= fwd_sel(id_rs2_used, id_rs2, ex_q, mem_q, wb_q);
            end else begin
                ex_q      <= '0;
                ex_load_q <= 1'b0;
                fwd_a     <= 2'b00;
                fwd_b     <= 2'b00;
            end
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined RISC core (IF/ID/EX/MEM/WB). It tracks destination-register tags of the EX, MEM and WB stages in an internal shadow pipeline. It produces registered operand-forward selects aligned with the EX stage, a combinational load-use stall, and a saturating stall counter for performance measurement. It replaces the fixed all-zero forward selects of the previous generation.

Parameters:
REG_AW, 3, register address width (2**REG_AW architectural registers)
R0_IS_ZERO, 1, 1 = register 0 is hardwired zero; writes to r0 never forward or stall
CNT_W, 16, width of stall_count

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_AW  ID source A register
id_rs2  in  REG_AW  ID source B register
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_AW  ID destination register
id_wr_en  in  1  instruction writes rd
id_is_load  in  1  instruction is a load (data available end of MEM)
flush  in  1  branch taken in EX: kill ID instruction
stall  out  1  combinational; hold PC and IF/ID, inject EX bubble
fwd_a  out  2  registered; EX operand A select
fwd_b  out  2  registered; EX operand B select
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous, active-high. On rst: all stage valid bits 0, tags 0, fwd_a = fwd_b = 2'b00, stall_count = 0. Reset mid-operation discards all in-flight tags; stall reads 0 during the first cycle after reset.
- Shadow pipeline: per stage {valid, rd, wr, load} for EX, MEM, WB. Each edge: WB <= MEM, MEM <= EX. EX <= ID fields when id_valid & !stall & !flush; otherwise EX <= bubble (valid 0).
- A stage "produces r" iff valid & wr & rd == r & !(R0_IS_ZERO & r == 0).
- Load-use stall: stall = !flush & id_valid & EX.valid & EX.load & EX produces a used ID source (rs1 with rs1_used, or rs2 with rs2_used). Single-cycle stall per load: the next cycle the load sits in MEM, so stall drops and forwarding resolves it.
- Forward encoding (per used source; unused source -> 00): 2'b10 = EX/MEM ALU result, 2'b01 = MEM/WB result (ALU or load), 2'b11 = retired-result latch (value written to regfile on the previous edge), 2'b00 = register file.
- Next-value rule at each edge where ID enters EX: current EX produces src -> 10; else current MEM produces src -> 01; else current WB produces src -> 11; else 00. Youngest producer wins.
- If EX receives a bubble (stall, flush or !id_valid), fwd_a/fwd_b <= 00.
- A load in current EX never yields 10: that case is by definition a stall.
- flush and stall together: flush wins. stall = 0, EX gets a bubble, counter unchanged.
- stall_count increments by 1 on each edge with stall = 1 and saturates at 2**CNT_W-1. Only rst clears it.
- Latency: fwd selects valid in the same cycle the consumer is in EX, i.e. 1 edge after the decision in ID. stall has 0-cycle latency.

Test Plan:
- After rst: ADD r1 (wr) then ADD r2 <- r1,r3 back-to-back -> in consumer's EX cycle fwd_a = 10, fwd_b = 00, stall never asserted.
- Producer r1, one independent instruction, consumer reads r1 on both sources -> fwd_a = fwd_b = 01. With two independent instructions between -> fwd_a = fwd_b = 11. With three -> 00.
- LOAD r4 then ADD r5 <- r4,r0 -> stall = 1 for exactly one cycle, EX bubble with fwd 00, then consumer in EX with fwd_a = 01; stall_count = 1.
- Write to r0 (R0_IS_ZERO = 1), then consumer of r0, and LOAD r0 then consumer of r0 -> fwd 00, no stall. Same sequence with R0_IS_ZERO = 0 -> 10 and one stall cycle respectively.
- Load-use condition with flush = 1 the same cycle -> stall = 0, EX bubble, stall_count unchanged. Assert rst while a load-use stall is pending -> next cycle stall = 0, fwd 00, stall_count = 0.
- CNT_W = 2: force 5 load-use stalls -> stall_count reaches 3 and holds.
